// File: rtl/rlwe_pkg.sv
// Shared RLWE types and constants used by the MPRF-side vector datapaths.
package rlwe_pkg;

   localparam int LANE       = 4;
   localparam int XLEN       = 32;
   localparam int LANE_IDX_W = $clog2(LANE);

   typedef logic [LANE-1:0][XLEN-1:0] type_vector;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/rlwe_vec_lane_mux.sv
// Combinational lane select from a full vector register value.
module rlwe_vec_lane_mux
   import rlwe_pkg::*;
(
   input  type_vector              vec_i,
   input  logic [LANE_IDX_W-1:0]   sel_i,
   output logic [XLEN-1:0]         lane_o
);

   assign lane_o = vec_i[sel_i];

endmodule

// File: rtl/rlwe_vec_store_ser.sv
// Vector-store serializer: snapshots one MPRF vector register, then streams
// its lanes to data memory one word per accepted request.
module rlwe_vec_store_ser
   import rlwe_pkg::*;
#(
   parameter int LANE = rlwe_pkg::LANE,
   parameter int XLEN = rlwe_pkg::XLEN,
   parameter int AW   = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [AW-1:0]        cmd_rs_addr,
   input  logic [31:0]          cmd_base_addr,
   input  logic                 kill,
   output logic [AW-1:0]        mprf_rs_addr,
   output logic                 mprf_rs_is_vector,
   input  logic [LANE*XLEN-1:0] mprf_rs_data,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [31:0]          dmem_addr,
   output logic [XLEN-1:0]      dmem_wdata,
   input  logic                 dmem_ack,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   state_t                  state_q, state_d;
   logic [LANE_IDX_W-1:0]   lane_q, lane_d;
   logic [AW-1:0]           rs_q, rs_d;
   logic [31:0]             base_q, base_d;
   type_vector              vec_q, vec_d;
   logic                    err_q, err_d;

   logic                    cmd_aligned;
   logic                    accept;
   logic                    last_lane;
   logic [XLEN-1:0]         lane_data;

   assign cmd_aligned = (cmd_base_addr[1:0] == 2'b00);
   // kill outranks a new command so a flushed instruction never starts a store
   assign accept      = (state_q == IDLE) && cmd_valid && !kill && cmd_aligned;
   assign last_lane   = (lane_q == LANE_IDX_W'(LANE-1));

   rlwe_vec_lane_mux u_lane_mux (
      .vec_i  (vec_q),
      .sel_i  (lane_q),
      .lane_o (lane_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = READ;
         end
         READ: begin
            state_d = kill ? IDLE : SEND;
         end
         SEND: begin
            if (kill)                       state_d = IDLE;
            else if (dmem_ack && last_lane) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready    = 1'b0;
      busy         = 1'b1;
      mprf_rs_addr = '0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      done         = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         READ: begin
            mprf_rs_addr = rs_q;
         end
         SEND: begin
            dmem_req = 1'b1;
            dmem_we  = 1'b1;
         end
         DONE: begin
            done = !kill;
         end
         default: ;
      endcase
   end

   assign mprf_rs_is_vector = 1'b1;
   // 32-bit wraparound past the top of the address space is intentional
   assign dmem_addr         = base_q + (32'(lane_q) << 2);
   assign dmem_wdata        = lane_data;
   assign err               = err_q;

   always_comb begin
      lane_d = lane_q;
      rs_d   = rs_q;
      base_d = base_q;
      vec_d  = vec_q;
      err_d  = (state_q == IDLE) && cmd_valid && !kill && !cmd_aligned;
      if (accept) begin
         lane_d = '0;
         rs_d   = cmd_rs_addr;
         base_d = cmd_base_addr;
      end
      // snapshot here so later MPRF writes cannot disturb lanes in flight
      if (state_q == READ) begin
         vec_d = type_vector'(mprf_rs_data);
      end
      if ((state_q == SEND) && dmem_ack && !kill && !last_lane) begin
         lane_d = lane_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q <= '0;
         rs_q   <= '0;
         base_q <= '0;
         vec_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         lane_q <= lane_d;
         rs_q   <= rs_d;
         base_q <= base_d;
         vec_q  <= vec_d;
         err_q  <= err_d;
      end
   end

endmodule

// File: doc/rlwe_vec_store_ser.md
Name: rlwe_vec_store_ser

Overview: Vector-store serializer on the EXU side of the RLWE multi-port register file. It accepts a store command naming a vector register and a word-aligned base address. It reads the whole vector through one MPRF read port and captures it. It then streams the lanes one word at a time to the data-memory request interface with a req/ack handshake. This is the read-and-drain counterpart to the vector write path into the MPRF.

Parameters:
LANE, 4, number of XLEN-bit lanes per vector register (matches `LANE)
XLEN, 32, lane width in bits
AW, 5, MPRF address width (4 when RVE)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  store command valid
cmd_ready  out  1  serializer can accept a command
cmd_rs_addr  in  AW  source vector register
cmd_base_addr  in  32  byte base address for lane 0
kill  in  1  pipeline flush; abort the current command
mprf_rs_addr  out  AW  MPRF read address
mprf_rs_is_vector  out  1  select the vector bank; constant 1
mprf_rs_data  in  LANE*XLEN  type_vector read data (combinational from MPRF)
dmem_req  out  1  memory write request
dmem_we  out  1  write enable; 1 whenever dmem_req
dmem_addr  out  32  byte address of the current lane
dmem_wdata  out  XLEN  current lane data
dmem_ack  in  1  request accepted this cycle
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the last lane is acked
err  out  1  one-cycle pulse when a command is rejected for misalignment

Behaviour:
- FSM states: IDLE, READ, SEND, DONE. Encoding is state_t.
- Reset (async, rst_n=0):
  - state=IDLE; lane counter, captured vector and address registers cleared.
  - All outputs 0 except cmd_ready=1 and mprf_rs_is_vector=1.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid with cmd_base_addr[1:0]!=0: err=1 the next cycle, stay IDLE, issue no memory traffic.
  - On cmd_valid with an aligned address: latch rs_addr and base, set lane=0, go to READ.
- READ (one cycle):
  - mprf_rs_addr = latched rs_addr.
  - Capture mprf_rs_data into vec_q at the clock edge; go to SEND.
  - rs_addr==0 is legal; the MPRF returns 0, so LANE zero words are stored.
- SEND:
  - dmem_req=1, dmem_addr = base + 4*lane, dmem_wdata = vec_q[lane].
  - Outputs hold stable until dmem_ack.
  - On ack with lane<LANE-1: lane++.
  - On ack with lane==LANE-1: go to DONE.
  - Ack in the same cycle that req first rises is allowed, so the zero-wait rate is one lane per cycle.
- DONE: done=1 for one cycle, then IDLE. cmd_ready=0 in DONE.
- Latency: command accepted at cycle 0 gives READ at cycle 1, the first dmem_req at cycle 2, and with zero-wait ack done at cycle LANE+2.
- Address arithmetic is 32-bit modulo; wrap past 0xFFFFFFFC continues at 0x00000000 with no error.
- kill:
  - In READ, SEND or DONE: return to IDLE next cycle, drop dmem_req, no done pulse.
  - A lane acked in the same cycle as kill counts as written; remaining lanes are not sent.
  - kill in IDLE has priority over cmd_valid; the command is not accepted.
- Read-after-write: the vector is snapshotted in READ. Later MPRF writes to the same register do not affect lanes already captured.
- dmem_ack outside SEND is ignored.
- Reset mid-SEND drops dmem_req immediately (asynchronous).

Decomposition:
- The shared package rlwe_pkg holds:
  - type_vector (packed [LANE-1:0][XLEN-1:0])
  - the LANE/XLEN constants
  - the state_t enum
  - the LANE_IDX_W = $clog2(LANE) constant
- Sub-module rlwe_vec_lane_mux: combinational selection of lane i from type_vector. It is reused by the future vector-load path.

Test Plan:
1. Vector reg 5 = {0x44,0x33,0x22,0x11} (lane3..0), base 0x1000, ack always 1 -> stores (0x1000,0x11), (0x1004,0x22), (0x1008,0x33), (0x100C,0x44) in consecutive cycles; done at cycle 6; cmd_ready low from cycle 1 to 6.
2. Same command with ack delayed 3 cycles on lane 1 -> addr 0x1004 and data 0x22 held for 4 cycles; no lane skipped or duplicated; done at cycle 9.
3. cmd_rs_addr=0, base 0x2000 -> four stores of 0x0 at 0x2000..0x200C; done pulses.
4. base 0x1002 -> err pulse at cycle 1; dmem_req never asserted; cmd_ready stays 1.
5. kill asserted while lane 1 is pending -> dmem_req low next cycle; no done; a new command is accepted the following cycle and starts from lane 0.
6. base 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; plus an MPRF write to reg 5 during SEND, which must leave the streamed data unchanged.
